// File: rtl/lpif_dstrm_protid_arbiter_pkg.sv
// Shared types and widths for the LPIF downstream protocol-ID arbiter.
//   PROTID_W     : width of the protocol ID / requester index
//   LPIF_STATE_W : width of the forwarded LPIF state
//   arb_state_e  : arbiter FSM states
package lpif_arb_pkg;

  localparam int PROTID_W     = 2;
  localparam int LPIF_STATE_W = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_e;

endpackage

// File: rtl/lpif_dstrm_protid_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector, one bit per requester
//   ptr    : index of the previous winner; search starts at ptr+1 mod NUM_REQ
//   winner : index of the first requesting entry found
//   found  : 1 when any request bit is set
module lpif_rr_pick
  import lpif_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [PROTID_W-1:0] ptr,
  output logic [PROTID_W-1:0] winner,
  output logic                found
);

  // Padded to the full protid range so a 2-bit index is always in bounds.
  logic [3:0]          req_pad;
  logic [PROTID_W-1:0] cand;

  always_comb begin
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = req;
    winner                 = '0;
    found                  = 1'b0;
    cand                   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PROTID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_pad[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lpif_dstrm_protid_arbiter.sv
// Round-robin arbiter sharing the LPIF downstream channel among up to four
// protocol-layer requesters. A grant lasts for one packet, cut at MAX_BURST.
//   clk_wr, rst_wr_n      : clock, asynchronous active-low reset
//   link_enable           : beats are accepted only while high
//   link_state_in         : LPIF state, forwarded with one cycle delay
//   req_valid/last/data/crc/crc_valid : per-requester beat (data/crc packed)
//   req_ready             : per-requester accept
//   dstrm_*               : registered downstream beat
//   grant_active/grant_idx: FSM in BURST / current or last grant
//   burst_overrun         : sticky, set when a grant is cut at MAX_BURST
//   overrun_clear         : synchronous clear of burst_overrun (set wins)
module lpif_dstrm_protid_arbiter
  import lpif_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CRC_WIDTH  = 4,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk_wr,
  input  logic                          rst_wr_n,
  input  logic                          link_enable,
  input  logic [LPIF_STATE_W-1:0]       link_state_in,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*CRC_WIDTH-1:0]  req_crc,
  input  logic [NUM_REQ-1:0]            req_crc_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [LPIF_STATE_W-1:0]       dstrm_state,
  output logic [PROTID_W-1:0]           dstrm_protid,
  output logic [DATA_WIDTH-1:0]         dstrm_data,
  output logic                          dstrm_dvalid,
  output logic [CRC_WIDTH-1:0]          dstrm_crc,
  output logic                          dstrm_crc_valid,
  output logic                          dstrm_valid,
  output logic                          grant_active,
  output logic [PROTID_W-1:0]           grant_idx,
  output logic                          burst_overrun,
  input  logic                          overrun_clear
);

  localparam int                  CNT_W    = $clog2(MAX_BURST);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [PROTID_W-1:0] PTR_RST  = PROTID_W'(NUM_REQ - 1);

  arb_state_e          state, state_nxt;
  logic [PROTID_W-1:0] rr_ptr;
  logic [PROTID_W-1:0] pick_idx;
  logic                pick_found;
  logic [CNT_W-1:0]    beat_cnt;

  logic [3:0]            valid_pad, last_pad, crcv_pad;
  logic                  sel_valid, sel_last, sel_crcv;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [CRC_WIDTH-1:0]  sel_crc;
  logic                  accept, at_limit, burst_end;

  lpif_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .winner (pick_idx),
    .found  (pick_found)
  );

  // Granted requester's beat, selected by the registered grant index.
  always_comb begin
    valid_pad              = '0;
    last_pad               = '0;
    crcv_pad               = '0;
    valid_pad[NUM_REQ-1:0] = req_valid;
    last_pad[NUM_REQ-1:0]  = req_last;
    crcv_pad[NUM_REQ-1:0]  = req_crc_valid;
    sel_valid              = valid_pad[grant_idx];
    sel_last               = last_pad[grant_idx];
    sel_crcv               = crcv_pad[grant_idx];
    sel_data               = '0;
    sel_crc                = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PROTID_W'(i)) begin
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_crc  = req_crc[i*CRC_WIDTH +: CRC_WIDTH];
      end
    end
  end

  assign at_limit     = (beat_cnt == CNT_LAST);
  assign grant_active = (state == ARB_BURST);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    burst_end = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (link_enable && pick_found) state_nxt = ARB_BURST;
      end
      ARB_BURST: begin
        // Enable low holds the grant and counter; the burst simply pauses.
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = link_enable && (grant_idx == PROTID_W'(i));
        end
        accept    = link_enable && sel_valid;
        burst_end = accept && (sel_last || at_limit);
        if (burst_end) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Control stage: FSM, grant, round-robin pointer, beat counter, sticky flag.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state         <= ARB_IDLE;
      grant_idx     <= '0;
      rr_ptr        <= PTR_RST;
      beat_cnt      <= '0;
      burst_overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && state_nxt == ARB_BURST) begin
        grant_idx <= pick_idx;
        beat_cnt  <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (burst_end) rr_ptr <= grant_idx;
      if (accept && at_limit && !sel_last) begin
        burst_overrun <= 1'b1;
      end else if (overrun_clear) begin
        burst_overrun <= 1'b0;
      end
    end
  end

  // Output stage: data/CRC/protid hold between beats, valids pulse per beat.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      dstrm_state     <= '0;
      dstrm_protid    <= '0;
      dstrm_data      <= '0;
      dstrm_crc       <= '0;
      dstrm_valid     <= 1'b0;
      dstrm_dvalid    <= 1'b0;
      dstrm_crc_valid <= 1'b0;
    end else begin
      dstrm_state     <= link_state_in;
      dstrm_valid     <= accept;
      dstrm_dvalid    <= accept;
      dstrm_crc_valid <= accept && sel_crcv;
      if (accept) begin
        dstrm_data   <= sel_data;
        dstrm_crc    <= sel_crc;
        dstrm_protid <= grant_idx;
      end
    end
  end

endmodule
